// File: rtl/io_halt_controller.sv
// Processor clock-freeze controller for INPUT and HALT instructions.
// Freezes the divided processor clock and releases it after one debounced Enter press/release.
//
// state        | meaning
// IDLE         | processor running, watching Input_Req / Halt_Req
// WAIT_PRESS   | clock frozen, waiting for a debounced button press
// WAIT_RELEASE | value captured, waiting for a debounced button release
// RESUME       | clock released, waiting for one Proc_Clk rising edge
// HALTED       | clock frozen until Reset
module io_halt_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SW_WIDTH        = 10,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Proc_Clk,
  input  logic                  Input_Req,
  input  logic                  Halt_Req,
  input  logic                  Button,
  input  logic [SW_WIDTH-1:0]   Switches,
  output logic                  Interrupt,
  output logic [DATA_WIDTH-1:0] Input_Data,
  output logic                  Input_Valid,
  output logic                  Waiting,
  output logic                  Halted
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    RESUME,
    HALTED
  } state_t;

  state_t state, state_next;

  logic [1:0] btn_sync, req_sync, halt_sync, pclk_sync;
  logic       pclk_prev;
  logic       btn, req, halt, pclk_rise;

  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             capture;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_sync  <= '0;
      req_sync  <= '0;
      halt_sync <= '0;
      pclk_sync <= '0;
      pclk_prev <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[0], Button};
      req_sync  <= {req_sync[0], Input_Req};
      halt_sync <= {halt_sync[0], Halt_Req};
      pclk_sync <= {pclk_sync[0], Proc_Clk};
      pclk_prev <= pclk_sync[1];
    end
  end

  assign btn       = btn_sync[1];
  assign req       = req_sync[1];
  assign halt      = halt_sync[1];
  assign pclk_rise = pclk_sync[1] & ~pclk_prev;

  // Saturating increment so a long stable level never wraps back to zero.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    capture    = 1'b0;
    Interrupt  = 1'b0;
    Waiting    = 1'b0;
    Halted     = 1'b0;
    case (state)
      IDLE: begin
        if (halt) begin
          state_next = HALTED;
        end else if (req) begin
          state_next = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        Interrupt = 1'b1;
        Waiting   = 1'b1;
        if (btn) begin
          if (cnt == CNT_LAST) begin
            capture    = 1'b1;
            state_next = WAIT_RELEASE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      WAIT_RELEASE: begin
        Interrupt = 1'b1;
        if (!btn) begin
          if (cnt == CNT_LAST) begin
            state_next = RESUME;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      RESUME: begin
        // Request lines still reflect the frozen instruction; only a new processor edge moves on.
        if (pclk_rise) begin
          state_next = IDLE;
        end
      end
      HALTED: begin
        Interrupt = 1'b1;
        Halted    = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      Input_Data  <= '0;
      Input_Valid <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      Input_Valid <= capture;
      if (capture) begin
        Input_Data <= DATA_WIDTH'(Switches);
      end
    end
  end

endmodule

// File: tb/tb_io_halt_controller.sv
// Bench for io_halt_controller with a short debounce window.
// Captures are checked against a queue of expected switch values.
module tb_io_halt_controller;

  localparam int DEB = 4;
  localparam int SWW = 10;
  localparam int DW  = 32;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           Proc_Clk;
  logic           Input_Req;
  logic           Halt_Req;
  logic           Button;
  logic [SWW-1:0] Switches;
  logic           Interrupt;
  logic [DW-1:0]  Input_Data;
  logic           Input_Valid;
  logic           Waiting;
  logic           Halted;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int irise  = 0;
  logic prev_valid = 1'b0;
  logic prev_int   = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;

  io_halt_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_WIDTH(SWW),
    .DATA_WIDTH(DW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Proc_Clk(Proc_Clk),
    .Input_Req(Input_Req),
    .Halt_Req(Halt_Req),
    .Button(Button),
    .Switches(Switches),
    .Interrupt(Interrupt),
    .Input_Data(Input_Data),
    .Input_Valid(Input_Valid),
    .Waiting(Waiting),
    .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every Input_Valid pulse must match the oldest expected capture.
  always @(negedge Clk) begin
    if (Input_Valid === 1'b1) begin
      vcount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL capture_unexpected: Input_Data=%h with no capture expected", Input_Data);
      end else begin
        exp_d = exp_q.pop_front();
        if (Input_Data !== exp_d) begin
          errors++;
          $display("FAIL capture_data: got %h expected %h", Input_Data, exp_d);
        end
      end
      checks++;
      if (prev_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_width: Input_Valid high two cycles in a row");
      end
    end
    if (Interrupt === 1'b1 && prev_int === 1'b0) irise++;
    prev_valid = Input_Valid;
    prev_int   = Interrupt;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_seq(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1 Button = seq[i];
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Button = 1'b1; Input_Req = 1'b1; Halt_Req = 1'b0;
    Proc_Clk = 1'b0; Switches = '0;
    cyc(3);
    checks++;
    if ({Interrupt, Input_Data, Input_Valid, Waiting, Halted} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got int=%b data=%h valid=%b wait=%b halt=%b expected all 0",
               Interrupt, Input_Data, Input_Valid, Waiting, Halted);
    end
    Reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk); @(negedge Clk);
      checks++;
      if (Interrupt !== (k == 3)) begin
        errors++;
        $display("FAIL req_latency edge %0d: Interrupt=%b expected %b", k, Interrupt, k == 3);
      end
    end
    checks++;
    if (Waiting !== 1'b1) begin
      errors++;
      $display("FAIL req_waiting: Waiting=%b expected 1", Waiting);
    end
    Button = 1'b0;
    cyc(4);
  endtask

  task automatic test_debounce_press;
    Switches = 10'h2A5;
    exp_q.push_back(32'h0000_02A5);
    drive_seq(8'b0010_1101, 6);
    for (int k = 1; k <= 6; k++) begin
      @(posedge Clk); @(negedge Clk);
      checks++;
      if (Input_Valid !== (k == 6)) begin
        errors++;
        $display("FAIL press_timing step %0d: Input_Valid=%b expected %b", k, Input_Valid, k == 6);
      end
    end
    checks++;
    if (Input_Data !== 32'h0000_02A5) begin
      errors++;
      $display("FAIL press_data: got %h expected 000002a5", Input_Data);
    end
    @(posedge Clk); @(negedge Clk);
    checks++;
    if ({Input_Valid, Interrupt, Waiting} !== 3'b010) begin
      errors++;
      $display("FAIL press_after: valid/int/wait=%b%b%b expected 010", Input_Valid, Interrupt, Waiting);
    end
  endtask

  task automatic test_debounce_release;
    int base;
    base = vcount;
    drive_seq(8'b0000_0010, 6);
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk); @(negedge Clk);
      checks++;
      if (Interrupt !== (k != 3)) begin
        errors++;
        $display("FAIL release_timing step %0d: Interrupt=%b expected %b", k, Interrupt, k != 3);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); @(negedge Clk);
      checks++;
      if ({Interrupt, Waiting} !== 2'b00) begin
        errors++;
        $display("FAIL resume_hold cycle %0d: int/wait=%b%b expected 00", k, Interrupt, Waiting);
      end
    end
    checks++;
    if (vcount != base) begin
      errors++;
      $display("FAIL release_no_capture: %0d extra captures expected 0", vcount - base);
    end
    Input_Req = 1'b0; Proc_Clk = 1'b1;
    cyc(6);
    Proc_Clk = 1'b0;
    cyc(4);
  endtask

  task automatic press_release(input logic [SWW-1:0] sw);
    Switches = sw;
    exp_q.push_back(DW'(sw));
    Button = 1'b1;
    for (int i = 0; i < 30 && Input_Valid !== 1'b1; i++) @(negedge Clk);
    checks++;
    if (Input_Valid !== 1'b1) begin
      errors++;
      $display("FAIL press_capture sw=%h: Input_Valid=%b expected 1 within 30 cycles", sw, Input_Valid);
    end
    cyc(1);
    Button = 1'b0;
    for (int i = 0; i < 30 && Interrupt !== 1'b0; i++) @(negedge Clk);
    checks++;
    if (Interrupt !== 1'b0) begin
      errors++;
      $display("FAIL release_unfreeze sw=%h: Interrupt=%b expected 0 within 30 cycles", sw, Interrupt);
    end
  endtask

  task automatic test_back_to_back;
    int base_v, base_i;
    base_v = vcount; base_i = irise;
    Input_Req = 1'b1;
    for (int i = 0; i < 20 && Interrupt !== 1'b1; i++) @(negedge Clk);
    checks++;
    if (Waiting !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_freeze: Waiting=%b expected 1", Waiting);
    end
    press_release(10'h001);
    cyc(4);
    checks++;
    if (Interrupt !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resume_wait: Interrupt=%b expected 0 before Proc_Clk edge", Interrupt);
    end
    Proc_Clk = 1'b1;
    for (int i = 0; i < 20 && Interrupt !== 1'b1; i++) @(negedge Clk);
    checks++;
    if (Waiting !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_freeze: Waiting=%b expected 1", Waiting);
    end
    Proc_Clk = 1'b0;
    press_release(10'h3FF);
    cyc(2);
    checks++;
    if (vcount - base_v != 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d expected 2", vcount - base_v);
    end
    checks++;
    if (irise - base_i != 2) begin
      errors++;
      $display("FAIL b2b_freeze_count: got %0d expected 2", irise - base_i);
    end
    checks++;
    if (Input_Data !== 32'h0000_03FF) begin
      errors++;
      $display("FAIL b2b_data: got %h expected 000003ff", Input_Data);
    end
    Input_Req = 1'b0; Proc_Clk = 1'b1;
    cyc(5);
    Proc_Clk = 1'b0;
    cyc(5);
  endtask

  task automatic test_halt;
    int base_v;
    base_v = vcount;
    Halt_Req = 1'b1; Input_Req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk); @(negedge Clk);
      checks++;
      if ({Halted, Interrupt} !== {(k == 3), (k == 3)}) begin
        errors++;
        $display("FAIL halt_latency edge %0d: halted/int=%b%b expected %b%b", k, Halted, Interrupt, k == 3, k == 3);
      end
    end
    checks++;
    if (Waiting !== 1'b0) begin
      errors++;
      $display("FAIL halt_priority: Waiting=%b expected 0", Waiting);
    end
    Button = 1'b1; cyc(12);
    Button = 1'b0; cyc(12);
    Halt_Req = 1'b0; Input_Req = 1'b0; Proc_Clk = 1'b1;
    cyc(6);
    Proc_Clk = 1'b0;
    cyc(6);
    checks++;
    if ({Halted, Interrupt, Waiting} !== 3'b110) begin
      errors++;
      $display("FAIL halt_sticky: halted/int/wait=%b%b%b expected 110", Halted, Interrupt, Waiting);
    end
    checks++;
    if (vcount != base_v || Input_Data !== 32'h0000_03FF) begin
      errors++;
      $display("FAIL halt_ignores_button: captures=%0d data=%h expected 0 and 000003ff", vcount - base_v, Input_Data);
    end
    Reset = 1'b1;
    #2;
    checks++;
    if ({Halted, Interrupt} !== 2'b00) begin
      errors++;
      $display("FAIL halt_reset: halted/int=%b%b expected 00", Halted, Interrupt);
    end
    cyc(2);
    Reset = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset_mid;
    int base_v;
    Switches = 10'h155;
    Input_Req = 1'b1;
    for (int i = 0; i < 20 && Interrupt !== 1'b1; i++) @(negedge Clk);
    exp_q.push_back(32'h0000_0155);
    Button = 1'b1;
    for (int i = 0; i < 30 && Input_Valid !== 1'b1; i++) @(negedge Clk);
    checks++;
    if (Input_Valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_capture: Input_Valid=%b expected 1 within 30 cycles", Input_Valid);
    end
    cyc(2);
    checks++;
    if ({Interrupt, Waiting} !== 2'b10) begin
      errors++;
      $display("FAIL mid_wait_release: int/wait=%b%b expected 10", Interrupt, Waiting);
    end
    base_v = vcount;
    Reset = 1'b1;
    #2;
    checks++;
    if (Interrupt !== 1'b0 || Input_Data !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: int=%b data=%h expected 0 and 00000000", Interrupt, Input_Data);
    end
    Input_Req = 1'b0; Button = 1'b0;
    cyc(2);
    Reset = 1'b0;
    cyc(10);
    checks++;
    if ({Interrupt, Waiting, Halted} !== 3'b000 || vcount != base_v) begin
      errors++;
      $display("FAIL mid_stay_idle: int/wait/halt=%b%b%b captures=%0d expected 000 and 0",
               Interrupt, Waiting, Halted, vcount - base_v);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_press();
    test_debounce_release();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected captures never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_halt_controller.md
Name: io_halt_controller

Overview:
Drives the Interrupt (clock-freeze) input of the processor clock divider. When the processor executes an input instruction or a halt, the block freezes the processor clock. For an input instruction it releases the clock after one debounced press-and-release of the board Enter button, and presents the latched switch value to the processor. Sits between the board I/O (button, switches), the processor control unit and the clock divider, all on the fast board clock.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable Clk cycles needed to accept a button level change (≥2)
SW_WIDTH, 10, number of board switches
DATA_WIDTH, 32, processor input-data width (≥SW_WIDTH)

Ports:
Clk  in  1  fast board clock, the same clock that feeds the clock divider
Reset  in  1  asynchronous, active-high; clears all state
Proc_Clk  in  1  divided processor clock, sampled as data for edge detection only
Input_Req  in  1  processor control: current instruction is INPUT (level, Proc_Clk domain)
Halt_Req  in  1  processor control: current instruction is HALT (level, Proc_Clk domain)
Button  in  1  raw Enter pushbutton, active-high, asynchronous
Switches  in  SW_WIDTH  raw board switches
Interrupt  out  1  to clock divider; 1 = freeze processor clock
Input_Data  out  DATA_WIDTH  latched switch value, zero-extended
Input_Valid  out  1  one-Clk pulse when Input_Data is updated
Waiting  out  1  LED: waiting for the user's button press
Halted  out  1  LED: processor permanently halted

Behaviour:
- Synchronizers: Button, Input_Req, Halt_Req and Proc_Clk each pass through a 2-FF synchronizer (2 Clk latency). A Proc_Clk rising edge = synced value 1 while the previous synced value was 0. Switches are sampled directly at the capture edge (they are static while Waiting).
- Reset values: Interrupt=0, Input_Data=0, Input_Valid=0, Waiting=0, Halted=0, state=IDLE, debounce counter=0, synchronizer flops=0. Reset mid-operation returns to IDLE immediately and drops Interrupt.
- States:
  - IDLE: Interrupt=0. If synced Halt_Req=1, go to HALTED. Else if synced Input_Req=1, go to WAIT_PRESS. Halt has priority when both are set.
  - WAIT_PRESS: Interrupt=1, Waiting=1. The debounce counter counts consecutive cycles of synced Button=1 and clears to 0 on any 0. When the counter reaches DEBOUNCE_CYCLES-1 with Button still 1:
    - Input_Data <= zero-extended Switches, and Input_Valid=1 for that one cycle.
    - Clear the counter and go to WAIT_RELEASE.
  - WAIT_RELEASE: Interrupt=1, Waiting=0. The same counter rule is applied for synced Button=0. On acceptance, go to RESUME. One physical press produces exactly one capture.
  - RESUME: Interrupt=0. Input_Req and Halt_Req are ignored, because they stay at the frozen instruction's value. On the first detected Proc_Clk rising edge, go to IDLE.
  - HALTED: Interrupt=1 and Halted=1, held until Reset. Button is ignored.
- Latency:
  - Raw Input_Req rise to Interrupt=1 is 3 Clk edges (2 sync + 1 state). The divider's divide ratio must give ≥4 Clk cycles per Proc_Clk half-period, so the freeze lands before the next processor edge.
  - Confirmed release to Interrupt=0 is 1 Clk.
- Input_Data holds its value until the next capture. Input_Valid is never high for more than 1 cycle.
- Bounce shorter than DEBOUNCE_CYCLES in either wait state only restarts the counter. It never causes a state change.
- A button held down when entering WAIT_PRESS is accepted after DEBOUNCE_CYCLES cycles. This is a legal press.
- Back-to-back INPUT instructions: the second request is seen only after RESUME observes a Proc_Clk edge. Each instruction therefore needs its own press.
- Counter width is clog2(DEBOUNCE_CYCLES)+1 bits. It saturates and does not wrap.

Test Plan:
- Reset with Button=1 and Input_Req=1 → all outputs 0. After release, Interrupt=1 exactly 3 Clk edges later and Waiting=1.
- DEBOUNCE_CYCLES=4, Switches=10'h2A5, Button pulses of 1-0-1-1-0 then held 1 → no capture until 4 consecutive synced highs. Then Input_Data=32'h000002A5 with a single-cycle Input_Valid.
- Button released with bounce 0-1-0-0-0-0 → Interrupt drops 1 Clk after the 4th consecutive synced 0, state is RESUME, and Interrupt stays 0 while Input_Req is still 1.
- Two INPUT instructions separated by one Proc_Clk edge, with Switches 10'h001 then 10'h3FF → two freezes, two presses, Input_Data 0x001 then 0x3FF, and exactly two Input_Valid pulses.
- Halt_Req and Input_Req rise on the same cycle → HALTED, Interrupt=1, Halted=1, Waiting=0. Button presses change nothing; only Reset clears the state.
- Reset asserted in WAIT_RELEASE → Interrupt=0 and Input_Data=0 asynchronously. After deassertion with Input_Req=0, the block stays in IDLE.
